// File: rtl/hht_mem_responder.sv
// rtl/hht_mem_responder.sv - dual-read-port word memory with register file, clear engine and miss counter
//
// Ports:
//   Clk, Rst                 - rising-edge clock, synchronous active-low reset
//   mem_init / init_busy     - clear start pulse / clear in progress
//   cpu_we, cpu_sel,
//   cpu_addr, cpu_wdata      - CPU write port (cpu_sel: 0 = memory, 1 = register file)
//   RD, addr1, addr2         - read enable and the two read addresses
//   dataIn1, dataIn2         - registered read data (MISS_DATA for unmapped/blocked reads)
//   regaddr1, regaddr2       - register file read indices
//   base_dat_a, base_dat_b   - registered register file read data
//   miss_cnt                 - saturating count of MISS_DATA returns
module hht_mem_responder #(
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] MISS_DATA = 32'd99999
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        mem_init,
    output logic        init_busy,
    input  logic        cpu_we,
    input  logic        cpu_sel,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        RD,
    input  logic [31:0] addr1,
    input  logic [31:0] addr2,
    output logic [31:0] dataIn1,
    output logic [31:0] dataIn2,
    input  logic [4:0]  regaddr1,
    input  logic [4:0]  regaddr2,
    output logic [31:0] base_dat_a,
    output logic [31:0] base_dat_b,
    output logic [15:0] miss_cnt
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t             state;
    logic [MEM_AW-1:0]  ptr;
    logic [31:0]        mem  [DEPTH];
    logic [31:0]        regs [32];

    function automatic logic is_mapped(input logic [31:0] a);
        return (a >> MEM_AW) == 32'd0;
    endfunction

    logic        map1, map2, map_w;
    logic        miss1, miss2;
    logic        mem_we, reg_we;
    logic [16:0] miss_sum;
    logic [15:0] miss_next;

    assign map1  = is_mapped(addr1);
    assign map2  = is_mapped(addr2);
    assign map_w = is_mapped(cpu_addr);

    // init_busy mirrors state == CLEAR, so it doubles as the read/write block
    assign miss1 = RD && (init_busy || !map1);
    assign miss2 = RD && (init_busy || !map2);

    assign mem_we = !init_busy && cpu_we && !cpu_sel && map_w;
    assign reg_we = !init_busy && cpu_we && cpu_sel && (cpu_addr[4:0] != 5'd0);

    assign miss_sum  = {1'b0, miss_cnt} + 17'(miss1) + 17'(miss2);
    assign miss_next = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];

    // Register 0 is hard zero; a same-cycle write forwards straight to the read
    function automatic logic [31:0] reg_read(input logic [4:0] idx);
        if (idx == 5'd0)
            return 32'd0;
        else if (reg_we && (idx == cpu_addr[4:0]))
            return cpu_wdata;
        else
            return regs[idx];
    endfunction

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            ptr       <= '0;
            init_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_init) begin
                        state     <= CLEAR;
                        ptr       <= '0;
                        init_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (&ptr) begin
                        state     <= IDLE;
                        init_busy <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    // Memory is not reset; writes are suppressed during reset so an aborted
    // clear leaves the word at ptr untouched.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            if (state == CLEAR)
                mem[ptr] <= 32'd0;
            else if (mem_we)
                mem[cpu_addr[MEM_AW-1:0]] <= cpu_wdata;
        end
    end

    // Nonblocking reads of mem give read-before-write on address collisions
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            dataIn1  <= 32'd0;
            dataIn2  <= 32'd0;
            miss_cnt <= 16'd0;
        end else begin
            if (RD) begin
                dataIn1 <= miss1 ? MISS_DATA : mem[addr1[MEM_AW-1:0]];
                dataIn2 <= miss2 ? MISS_DATA : mem[addr2[MEM_AW-1:0]];
            end
            miss_cnt <= miss_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
            base_dat_a <= 32'd0;
            base_dat_b <= 32'd0;
        end else begin
            if (reg_we)
                regs[cpu_addr[4:0]] <= cpu_wdata;
            base_dat_a <= reg_read(regaddr1);
            base_dat_b <= reg_read(regaddr2);
        end
    end

endmodule

// File: doc/hht_mem_responder.md
HHT_MEM_RESPONDER -- requirements
Module: hht_mem_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, giving the log2 word depth of the backing memory.
REQ-002 SHALL have parameter MISS_DATA, default 32'd99999, giving the data returned for unmapped or blocked reads.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port mem_init, input, 1 bit: one-cycle pulse that starts a memory clear.
REQ-006 SHALL have port init_busy, output, 1 bit: high while a clear is running.
REQ-007 SHALL have port cpu_we, input, 1 bit: CPU write strobe.
REQ-008 SHALL have port cpu_sel, input, 1 bit: write target, 0 = memory, 1 = register file.
REQ-009 SHALL have port cpu_addr, input, 32 bits: CPU write address (word, or register index in [4:0]).
REQ-010 SHALL have port cpu_wdata, input, 32 bits: CPU write data.
REQ-011 SHALL have port RD, input, 1 bit: global read enable.
REQ-012 SHALL have port addr1, input, 32 bits: read address for port 1 (row-pointer / column-index stream).
REQ-013 SHALL have port addr2, input, 32 bits: read address for port 2 (value / vector stream).
REQ-014 SHALL have port dataIn1, output, 32 bits: port 1 read data.
REQ-015 SHALL have port dataIn2, output, 32 bits: port 2 read data.
REQ-016 SHALL have port regaddr1, input, 5 bits: register-file index A.
REQ-017 SHALL have port regaddr2, input, 5 bits: register-file index B.
REQ-018 SHALL have port base_dat_a, output, 32 bits: register contents at regaddr1.
REQ-019 SHALL have port base_dat_b, output, 32 bits: register contents at regaddr2.
REQ-020 SHALL have port miss_cnt, output, 16 bits: saturating count of reads that returned MISS_DATA.

Function
REQ-021 SHALL contain a 2^MEM_AW x 32 memory with two read ports and one CPU write port.
REQ-022 SHALL, for an address with addr[31:MEM_AW] == 0, count it as mapped; any other address is unmapped.
REQ-023 SHALL register dataInN = mem[addrN] one cycle after the rising edge when RD = 1 and addrN is mapped.
REQ-024 SHALL register dataInN = MISS_DATA when RD = 1 and addrN is unmapped, or RD = 1 while init_busy = 1.
REQ-025 SHALL hold dataInN at its previous value when RD = 0.
REQ-026 SHALL return the old memory contents when a read and a CPU write hit the same address in the same cycle (read-before-write).
REQ-027 SHALL serve the same address on both read ports in the same cycle, with identical data on both.
REQ-028 SHALL ignore CPU memory writes to unmapped addresses, and all CPU writes while init_busy = 1.
REQ-029 SHALL contain a 32 x 32 register file; register 0 always reads 0 and writes to it are ignored.
REQ-030 SHALL register base_dat_a = reg[regaddr1] and base_dat_b = reg[regaddr2] every cycle (1-cycle latency, RD-independent).
REQ-031 SHALL return the new value when a register-file write and a read of the same index occur in the same cycle (write-through bypass).
REQ-032 SHALL implement a state machine with states IDLE and CLEAR.
REQ-033 SHALL move IDLE -> CLEAR on mem_init = 1, zero the clear pointer, and raise init_busy in that cycle.
REQ-034 SHALL, in CLEAR, write 0 to mem[ptr] and increment ptr each cycle.
REQ-035 SHALL return CLEAR -> IDLE after ptr reaches 2^MEM_AW-1, with init_busy low the following cycle; a clear takes exactly 2^MEM_AW cycles.
REQ-036 SHALL ignore mem_init while in CLEAR.
REQ-037 SHALL increment miss_cnt by 1 for each port that returns MISS_DATA in a cycle (0, 1 or 2 per cycle) and saturate at 16'hFFFF.

Reset
REQ-038 SHALL, on Rst = 0 at a rising edge, set dataIn1, dataIn2, base_dat_a, base_dat_b and miss_cnt to 0, init_busy to 0, state to IDLE and all registers to 0.
REQ-039 SHALL leave memory contents unchanged on reset; only mem_init clears memory.
REQ-040 SHALL abort a clear in progress on reset and go to IDLE, leaving the uncleared words unchanged.

Verification
REQ-041 SHALL verify: write mem[3200] = 0 and mem[3201] = 14, RD = 1, addr1 = 3201 -> dataIn1 = 14 on the next edge.
REQ-042 SHALL verify: write reg6 = 3200 and reg15 = 34300, regaddr1 = 6, regaddr2 = 15 -> base_dat_a = 3200, base_dat_b = 34300 one cycle later; a write to reg0 -> reads 0.
REQ-043 SHALL verify: addr1 = 32'h0001_0000 and addr2 = 32'h0002_0000 in the same cycle -> both data outputs = 99999, miss_cnt increases by 2.
REQ-044 SHALL verify: CPU write mem[90] = 40 in the same cycle as a read of addr2 = 90 (old value 7) -> dataIn2 = 7, and the next read returns 40.
REQ-045 SHALL verify: with MEM_AW = 4, pulse mem_init -> init_busy high for 16 cycles, reads during the clear return 99999, then all words read 0.
REQ-046 SHALL verify: Rst = 0 at clear cycle 5 (MEM_AW = 4) -> IDLE, init_busy = 0, words 5..15 keep their pre-clear data.
